conff_multi: RTL and testbench
==============================

Name: conff_multi

Overview:
Parametrised successor to the single conditional-branch flip-flop.
- Evaluates a branch condition on a bus operand with a two-stage capture/evaluate pipeline.
- Writes the result into one of NUM_FLAGS condition flags selected by the instruction.
- Extends the condition set to eight codes, adds valid/busy handshaking, overrun detection and a saturating taken-branch counter.
- Sits beside the control unit: the bus feeds it, and the control unit reads q for branch decisions.

Parameters:
DATA_W, 32, operand width on bus_mux_out; sign bit is bit DATA_W-1
NUM_FLAGS, 4, number of condition flags; minimum 2
IDX_W, 2, flag index width; must equal ceil(log2(NUM_FLAGS))
CNT_W, 16, width of the taken-branch counter

Ports:
clk  input  1  clock; all state changes on rising edge
clr  input  1  reset, asynchronous, active-low
con_in  input  1  evaluate request (control signal)
ir_bits  input  3  condition code
flag_idx  input  IDX_W  destination flag for this evaluation
rd_idx  input  IDX_W  flag driven on q
bus_mux_out  input  DATA_W  operand
q  output  1  flags[rd_idx], combinational read
q_all  output  NUM_FLAGS  all flags
busy  output  1  high while in EVAL
valid  output  1  one-cycle pulse after a flag write
result  output  1  value last written; meaningful when valid=1
overrun  output  1  sticky: con_in arrived while busy
taken_count  output  CNT_W  saturating count of true results

Behaviour:
- Reset (clr=0, async, any state):
  - state=IDLE
  - flags=0, valid=0, result=0, overrun=0, taken_count=0
  - capture registers=0
  - q=0 and busy=0 immediately.
- Condition codes (operand x, signed DATA_W):
  - 000 x==0
  - 001 x!=0
  - 010 x>=0 (sign bit 0)
  - 011 x<0 (sign bit 1)
  - 100 x>0 (sign 0 and x!=0)
  - 101 x<=0 (sign 1 or x==0)
  - 110 always true
  - 111 never true
  - Codes 000-011 match the legacy 2-bit encoding.
- IDLE:
  - On an edge with con_in=1, register zero = (bus_mux_out==0), sign = bus_mux_out[DATA_W-1], ir_bits and flag_idx.
  - Go to EVAL.
  - The operand is not used after this edge.
- EVAL (busy=1), at the next edge:
  - Compute cond from the registered zero/sign/code.
  - flags[captured idx] <= cond; result <= cond; valid <= 1.
  - If cond=1 and taken_count is not all ones, taken_count increments.
  - Return to IDLE.
- Latency:
  - con_in sampled at edge E0 → flag, q_all and result updated at E1; valid is high from E1 to E2.
  - Throughput: one evaluation per 2 cycles. Back-to-back requests at E0 and E2 are both accepted.
- con_in=1 at an edge while in EVAL:
  - Request dropped, overrun <= 1 (sticky until clr).
  - The EVAL in progress completes normally.
- valid returns to 0 at the next edge unless another write occurs. Two writes cannot occur on consecutive edges.
- q is a combinational mux on rd_idx:
  - When rd_idx equals the flag being written at E1, q shows the new value from E1.
  - Out-of-range rd_idx or flag_idx (NUM_FLAGS not a power of 2): reads return 0, writes are discarded, but valid, result and taken_count still update.
- Non-target flags hold their values.
- Reset asserted mid-EVAL aborts the evaluation: no flag write, no valid pulse.
- Counter saturates at 2^CNT_W-1 and never wraps.

Test Plan:
1. Reset, then con_in with ir_bits=000, flag_idx=1, bus=0 → busy=1 for 1 cycle; at E1 flags=4'b0010, valid pulse 1 cycle, result=1, taken_count=1; rd_idx=1 gives q=1.
2. All codes on bus=32'h8000_0000, 0 and 5 → expected results:
   - 8000_0000: 0,1,0,1,0,1,1,0
   - 0: 1,0,1,0,0,1,1,0
   - 5: 0,1,1,0,1,0,1,0
3. con_in held high for 4 cycles, bus=7, code 100, idx=2 → two evaluations accepted (E0, E2), overrun=1 after E1, taken_count=2, flags[2]=1.
4. Operand change after capture: bus=0 at E0, bus=9 during EVAL, code 000 → result=1 (the operand captured at E0 is used).
5. clr pulsed low mid-EVAL → flags stay 0, no valid pulse, overrun=0, busy=0 immediately; a following request completes normally.
6. CNT_W=2, five code-110 evaluations → taken_count=3 and holds at 3; a code-111 evaluation writes 0 to its flag and leaves the count unchanged.

Source files
------------

// File: rtl/conff_multi.sv
// Conditional-branch flag file: captures a bus operand on request, evaluates one of
// eight condition codes the following cycle and writes the result into a selected flag.
module conff_multi #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_FLAGS = 4,
    parameter int unsigned IDX_W     = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 con_in,
    input  logic [2:0]           ir_bits,
    input  logic [IDX_W-1:0]     flag_idx,
    input  logic [IDX_W-1:0]     rd_idx,
    input  logic [DATA_W-1:0]    bus_mux_out,
    output logic                 q,
    output logic [NUM_FLAGS-1:0] q_all,
    output logic                 busy,
    output logic                 valid,
    output logic                 result,
    output logic                 overrun,
    output logic [CNT_W-1:0]     taken_count
);

    typedef enum logic {
        S_IDLE,
        S_EVAL
    } state_t;

    state_t                 r_state;
    logic                   r_zero;
    logic                   r_sign;
    logic [2:0]             r_code;
    logic [IDX_W-1:0]       r_idx;
    logic [NUM_FLAGS-1:0]   r_flags;
    logic                   r_valid;
    logic                   r_result;
    logic                   r_overrun;
    logic [CNT_W-1:0]       r_count;

    logic                   w_cond;
    logic                   w_q;

    // Only the zero and sign summaries of the operand are kept; the bus is free after capture.
    always_comb begin
        w_cond = 1'b0;
        case (r_code)
            3'b000:  w_cond = r_zero;
            3'b001:  w_cond = !r_zero;
            3'b010:  w_cond = !r_sign;
            3'b011:  w_cond = r_sign;
            3'b100:  w_cond = !r_sign && !r_zero;
            3'b101:  w_cond = r_sign || r_zero;
            3'b110:  w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    // Index match loop makes out-of-range indices read as 0 without a range check.
    always_comb begin
        w_q = 1'b0;
        for (int unsigned i = 0; i < NUM_FLAGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                w_q = r_flags[i];
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state   <= S_IDLE;
            r_zero    <= 1'b0;
            r_sign    <= 1'b0;
            r_code    <= '0;
            r_idx     <= '0;
            r_flags   <= '0;
            r_valid   <= 1'b0;
            r_result  <= 1'b0;
            r_overrun <= 1'b0;
            r_count   <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (con_in) begin
                        r_zero  <= (bus_mux_out == '0);
                        r_sign  <= bus_mux_out[DATA_W-1];
                        r_code  <= ir_bits;
                        r_idx   <= flag_idx;
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (con_in) begin
                        r_overrun <= 1'b1;
                    end
                    for (int unsigned i = 0; i < NUM_FLAGS; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_flags[i] <= w_cond;
                        end
                    end
                    r_result <= w_cond;
                    r_valid  <= 1'b1;
                    if (w_cond && (r_count != '1)) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign q           = w_q;
    assign q_all       = r_flags;
    assign busy        = (r_state == S_EVAL);
    assign valid       = r_valid;
    assign result      = r_result;
    assign overrun     = r_overrun;
    assign taken_count = r_count;

endmodule

// File: tb/tb_conff_multi.sv
// Directed scoreboard bench for conff_multi: a default instance and a small one
// (3 flags, 2-bit counter) for saturation and out-of-range indices.
module tb_conff_multi;

    logic        clk = 1'b0;
    logic        clr;

    logic        con0, con1;
    logic [2:0]  ir0, ir1;
    logic [1:0]  fi0, fi1, rd0, rd1;
    logic [31:0] bus0, bus1;
    logic        q0, q1, busy0, busy1, valid0, valid1, res0, res1, ovr0, ovr1;
    logic [3:0]  qall0;
    logic [2:0]  qall1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int n_cmp = 0;
    int n_err = 0;

    logic        sb0[$];
    logic        sb1[$];
    logic [3:0]  ef0;
    logic [2:0]  ef1;
    logic [15:0] ec0;
    logic [1:0]  ec1;

    always #5 clk = ~clk;

    conff_multi u0 (
        .clk(clk), .clr(clr), .con_in(con0), .ir_bits(ir0), .flag_idx(fi0), .rd_idx(rd0),
        .bus_mux_out(bus0), .q(q0), .q_all(qall0), .busy(busy0), .valid(valid0),
        .result(res0), .overrun(ovr0), .taken_count(cnt0)
    );

    conff_multi #(.DATA_W(32), .NUM_FLAGS(3), .IDX_W(2), .CNT_W(2)) u1 (
        .clk(clk), .clr(clr), .con_in(con1), .ir_bits(ir1), .flag_idx(fi1), .rd_idx(rd1),
        .bus_mux_out(bus1), .q(q1), .q_all(qall1), .busy(busy1), .valid(valid1),
        .result(res1), .overrun(ovr1), .taken_count(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_cond(input logic [2:0] c, input logic [31:0] x);
        logic signed [31:0] s;
        s = x;
        case (c)
            3'd0:    return x == 0;
            3'd1:    return x != 0;
            3'd2:    return s >= 0;
            3'd3:    return s < 0;
            3'd4:    return s > 0;
            3'd5:    return s <= 0;
            3'd6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (valid0) begin
            if (sb0.size() == 0) chk("u0_spurious_valid", 32'(valid0), 32'd0);
            else chk("u0_result", 32'(res0), 32'(sb0.pop_front()));
        end
        if (valid1) begin
            if (sb1.size() == 0) chk("u1_spurious_valid", 32'(valid1), 32'd0);
            else chk("u1_result", 32'(res1), 32'(sb1.pop_front()));
        end
    end

    // One evaluation on instance u; bus switches to 'late' while in EVAL.
    task automatic do_eval(input bit u, input logic [2:0] code, input logic [1:0] idx,
                           input logic [31:0] data, input logic [31:0] late, input logic [1:0] rd);
        logic e;
        e = model_cond(code, data);
        @(negedge clk);
        if (!u) begin
            con0 = 1'b1; ir0 = code; fi0 = idx; bus0 = data; rd0 = rd;
            sb0.push_back(e);
            if (idx < 2'd3 || idx == 2'd3) ef0[idx] = e;
            if (e && ec0 != 16'hFFFF) ec0 = ec0 + 16'd1;
        end else begin
            con1 = 1'b1; ir1 = code; fi1 = idx; bus1 = data; rd1 = rd;
            sb1.push_back(e);
            if (idx < 2'd3) ef1[idx] = e;
            if (e && ec1 != 2'd3) ec1 = ec1 + 2'd1;
        end
        @(negedge clk);
        if (!u) begin
            con0 = 1'b0; bus0 = late;
            chk("u0_busy_eval", 32'(busy0), 32'd1);
        end else begin
            con1 = 1'b0; bus1 = late;
            chk("u1_busy_eval", 32'(busy1), 32'd1);
        end
        @(negedge clk);
        if (!u) begin
            chk("u0_valid", 32'(valid0), 32'd1);
            chk("u0_busy_done", 32'(busy0), 32'd0);
            chk("u0_q_all", 32'(qall0), 32'(ef0));
            chk("u0_count", 32'(cnt0), 32'(ec0));
            chk("u0_q", 32'(q0), 32'(ef0[rd]));
        end else begin
            chk("u1_valid", 32'(valid1), 32'd1);
            chk("u1_q_all", 32'(qall1), 32'(ef1));
            chk("u1_count", 32'(cnt1), 32'(ec1));
            chk("u1_q", 32'(q1), (rd < 2'd3) ? 32'(ef1[rd]) : 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ops [3];
        ops[0] = 32'h8000_0000; ops[1] = 32'h0; ops[2] = 32'h5;
        clr = 1'b1;
        con0 = 0; ir0 = 0; fi0 = 0; rd0 = 0; bus0 = 0;
        con1 = 0; ir1 = 0; fi1 = 0; rd1 = 0; bus1 = 0;
        ef0 = '0; ef1 = '0; ec0 = '0; ec1 = '0;
        #1 clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_q_all", 32'(qall0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_count", 32'(cnt0), 32'd0);
        chk("rst_overrun", 32'(ovr0), 32'd0);
        chk("rst_q", 32'(q0), 32'd0);
        clr = 1'b1;

        // Basic zero test into flag 1
        do_eval(0, 3'b000, 2'd1, 32'd0, 32'd0, 2'd1);
        @(negedge clk);
        chk("valid_one_cycle", 32'(valid0), 32'd0);

        // Every code across negative, zero and positive operands
        for (int b = 0; b < 3; b++) begin
            for (int c = 0; c < 8; c++) begin
                do_eval(0, 3'(c), 2'(c % 4), ops[b], ~ops[b], 2'(c % 4));
            end
        end

        // Operand changes after capture
        do_eval(0, 3'b000, 2'd3, 32'd0, 32'd9, 2'd3);

        // con_in held high for four edges
        @(negedge clk);
        con0 = 1'b1; ir0 = 3'b100; fi0 = 2'd2; bus0 = 32'd7; rd0 = 2'd2;
        sb0.push_back(1'b1); sb0.push_back(1'b1);
        ef0[2] = 1'b1; ec0 = ec0 + 16'd2;
        @(negedge clk);
        chk("hold_busy_e0", 32'(busy0), 32'd1);
        chk("hold_ovr_e0", 32'(ovr0), 32'd0);
        @(negedge clk);
        chk("hold_ovr_e1", 32'(ovr0), 32'd1);
        chk("hold_busy_e1", 32'(busy0), 32'd0);
        @(negedge clk);
        chk("hold_busy_e2", 32'(busy0), 32'd1);
        @(negedge clk);
        con0 = 1'b0;
        chk("hold_q_all", 32'(qall0), 32'(ef0));
        chk("hold_count", 32'(cnt0), 32'(ec0));
        chk("hold_q", 32'(q0), 32'd1);
        chk("hold_ovr_sticky", 32'(ovr0), 32'd1);

        // Reset in the middle of EVAL
        @(negedge clk);
        con0 = 1'b1; ir0 = 3'b110; fi0 = 2'd0; bus0 = 32'd0;
        @(negedge clk);
        con0 = 1'b0;
        chk("abort_busy_pre", 32'(busy0), 32'd1);
        clr = 1'b0;
        #1;
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_q_all", 32'(qall0), 32'd0);
        chk("abort_ovr", 32'(ovr0), 32'd0);
        chk("abort_count", 32'(cnt0), 32'd0);
        ef0 = '0; ef1 = '0; ec0 = '0; ec1 = '0;
        @(negedge clk);
        clr = 1'b1;
        chk("abort_no_valid", 32'(valid0), 32'd0);
        do_eval(0, 3'b110, 2'd0, 32'd0, 32'd0, 2'd0);

        // Small instance: saturation, never-true code, out-of-range index
        for (int k = 0; k < 5; k++) do_eval(1, 3'b110, 2'd0, 32'd1, 32'd0, 2'd0);
        do_eval(1, 3'b110, 2'd1, 32'd0, 32'd0, 2'd1);
        do_eval(1, 3'b111, 2'd1, 32'd0, 32'd0, 2'd1);
        do_eval(1, 3'b110, 2'd3, 32'd0, 32'd0, 2'd3);

        @(negedge clk);
        chk("u0_sb_drained", 32'(sb0.size()), 32'd0);
        chk("u1_sb_drained", 32'(sb1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
